cam_cmd_queue: RTL and testbench

- Command front-end sitting directly upstream of the cam block; it feeds the cam.
- Buffers read, write and search commands from a producer in a small FIFO and issues them to the cam one at a time.
- Captures the cam's registered result and presents it on a valid/ready response port.
- Serialises traffic, so at most one cam operation is ever outstanding.

---
 rtl/cam_pkg.sv | 18 +
 rtl/cmd_fifo.sv | 43 ++++
 rtl/cam_cmd_queue.sv | 98 +++++++++
 tb/tb_cam_cmd_queue.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// cam_pkg: shared command/response types and FSM states for the cam command front-end
package cam_pkg;
    localparam int CAM_IDX_W = 5;
    localparam int CAM_DATA_W = 32;
    typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_SEARCH, OP_RSVD} cam_op_e;
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} cam_state_e;
    typedef struct packed {
        cam_op_e                 op;
        logic [CAM_IDX_W-1:0]    index;
        logic [CAM_DATA_W-1:0]   data;
    } cam_cmd_t;
    typedef struct packed {
        cam_op_e                 op;
        logic                    hit;
        logic [CAM_IDX_W-1:0]    index;
        logic [CAM_DATA_W-1:0]   data;
    } cam_rsp_t;
endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: synchronous FIFO of cam commands with naturally wrapping pointers
module cmd_fifo
    import cam_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  logic     pop,
    input  cam_cmd_t wdata,
    output cam_cmd_t rdata,
    output logic     full,
    output logic     empty
);
    localparam int AW = $clog2(DEPTH);
    cam_cmd_t mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic do_push, do_pop;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign rdata = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/cam_cmd_queue.sv
// cam_cmd_queue: serialising command front-end for the cam; define CAM_CMD_QUEUE_WR_ACK_EN to return a response for WRITEs
module cam_cmd_queue
    import cam_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IDX_W = CAM_IDX_W,
    parameter int DATA_W = CAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [IDX_W-1:0]  cmd_index,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              cam_read,
    output logic              cam_write,
    output logic              cam_search,
    output logic [IDX_W-1:0]  cam_index,
    output logic [DATA_W-1:0] cam_data,
    input  logic              cam_read_valid,
    input  logic [DATA_W-1:0] cam_read_value,
    input  logic              cam_search_valid,
    input  logic [IDX_W-1:0]  cam_search_index,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_op,
    output logic              rsp_hit,
    output logic [IDX_W-1:0]  rsp_index,
    output logic [DATA_W-1:0] rsp_data
);
    cam_state_e state, state_nxt;
    cam_cmd_t cmd, head, iss;
    cam_rsp_t rsp;
    logic empty, full, push, pop, rdy_en, wr_ack, issuing;
`ifdef CAM_CMD_QUEUE_WR_ACK_EN
    assign wr_ack = 1'b1;
`else
    assign wr_ack = 1'b0;
`endif
    assign cmd = '{op: cam_op_e'(cmd_op), index: cmd_index, data: cmd_data};
    // ready depends only on occupancy, so a pop never frees a slot in the same cycle
    assign cmd_ready = rdy_en && !full;
    assign push = cmd_valid && cmd_ready;
    assign pop = state == ST_IDLE && !empty;
    cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (cmd),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );
    assign cam_read = state == ST_ISSUE && iss.op == OP_READ;
    assign cam_write = state == ST_ISSUE && iss.op == OP_WRITE;
    assign cam_search = state == ST_ISSUE && iss.op == OP_SEARCH;
    assign issuing = cam_read || cam_write || cam_search;
    assign cam_index = issuing ? iss.index : '0;
    assign cam_data = issuing ? iss.data : '0;
    assign rsp_op = rsp.op;
    assign rsp_hit = rsp.hit;
    assign rsp_index = rsp.index;
    assign rsp_data = rsp.data;
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  state_nxt = empty ? ST_IDLE : ST_ISSUE;
            ST_ISSUE: state_nxt = (iss.op == OP_READ || iss.op == OP_SEARCH || (iss.op == OP_WRITE && wr_ack)) ? ST_WAIT : ST_IDLE;
            ST_WAIT:  state_nxt = ST_RESP;
            ST_RESP:  state_nxt = rsp_ready ? ST_IDLE : ST_RESP;
            default:  state_nxt = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            iss <= '0;
            rsp <= '0;
            rsp_valid <= 1'b0;
            rdy_en <= 1'b0;
        end else begin
            state <= state_nxt;
            rdy_en <= 1'b1;
            if (pop)
                iss <= head;
            if (state == ST_WAIT) begin
                rsp_valid <= 1'b1;
                rsp.op <= iss.op;
                rsp.hit <= iss.op == OP_READ ? cam_read_valid : iss.op == OP_SEARCH ? cam_search_valid : 1'b1;
                rsp.index <= iss.op == OP_SEARCH ? (cam_search_valid ? cam_search_index : '0) : iss.index;
                rsp.data <= iss.op == OP_READ ? cam_read_value : iss.data;
            end else if (state == ST_RESP && rsp_ready)
                rsp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cam_cmd_queue.sv
// tb_cam_cmd_queue: randomized bench checking cam_cmd_queue against a queue-based response model and a behavioural cam
module tb_cam_cmd_queue;
    localparam int DEPTH = 4;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cmd_valid = 1'b0, cmd_ready;
    logic [1:0] cmd_op = '0;
    logic [4:0] cmd_index = '0;
    logic [31:0] cmd_data = '0;
    logic cam_read, cam_write, cam_search;
    logic [4:0] cam_index;
    logic [31:0] cam_data;
    logic cam_read_valid, cam_search_valid;
    logic [31:0] cam_read_value;
    logic [4:0] cam_search_index;
    logic rsp_valid, rsp_ready = 1'b0, rsp_hit;
    logic [1:0] rsp_op;
    logic [4:0] rsp_index;
    logic [31:0] rsp_data;

    bit cm_vld [32];
    bit [31:0] cm_dat [32];
    bit m_vld [32];
    bit [31:0] m_dat [32];
    logic m_hit;
    logic [4:0] m_at;
    logic [39:0] exp_q [$];
    logic [39:0] got_q [$];
    logic [39:0] p_val;
    logic p_hold = 1'b0;
    int e_rd, e_wr, e_sr, n_rd, n_wr, n_sr, multi_err, hold_err;
    int n_cmp, n_fail;

    always #5 clk = ~clk;

    cam_cmd_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_index(cmd_index), .cmd_data(cmd_data),
        .cam_read(cam_read), .cam_write(cam_write), .cam_search(cam_search),
        .cam_index(cam_index), .cam_data(cam_data),
        .cam_read_valid(cam_read_valid), .cam_read_value(cam_read_value),
        .cam_search_valid(cam_search_valid), .cam_search_index(cam_search_index),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op),
        .rsp_hit(rsp_hit), .rsp_index(rsp_index), .rsp_data(rsp_data)
    );

    // behavioural cam: registered results one cycle after the strobe, lowest matching index wins
    always @(posedge clk) begin
        cam_read_valid <= 1'b0;
        cam_read_value <= '0;
        cam_search_valid <= 1'b0;
        cam_search_index <= '0;
        if (cam_write === 1'b1) begin
            cm_vld[cam_index] <= 1'b1;
            cm_dat[cam_index] <= cam_data;
        end
        if (cam_read === 1'b1) begin
            cam_read_valid <= cm_vld[cam_index];
            cam_read_value <= cm_dat[cam_index];
        end
        if (cam_search === 1'b1)
            for (int j = 31; j >= 0; j--)
                if (cm_vld[j] && cm_dat[j] == cam_data) begin
                    cam_search_valid <= 1'b1;
                    cam_search_index <= 5'(j);
                end
    end

    // reference model, response collector and protocol monitors
    always @(negedge clk) begin
        if (rst && cmd_valid && cmd_ready) begin
            case (cmd_op)
                2'd0: begin
                    e_rd++;
                    exp_q.push_back({2'd0, m_vld[cmd_index], cmd_index, m_dat[cmd_index]});
                end
                2'd1: begin
                    e_wr++;
                    m_vld[cmd_index] = 1'b1;
                    m_dat[cmd_index] = cmd_data;
`ifdef CAM_CMD_QUEUE_WR_ACK_EN
                    exp_q.push_back({2'd1, 1'b1, cmd_index, cmd_data});
`endif
                end
                2'd2: begin
                    e_sr++;
                    m_hit = 1'b0;
                    m_at = '0;
                    for (int j = 0; j < 32; j++)
                        if (!m_hit && m_vld[j] && m_dat[j] == cmd_data) begin
                            m_hit = 1'b1;
                            m_at = 5'(j);
                        end
                    exp_q.push_back({2'd2, m_hit, m_at, cmd_data});
                end
                default: ;
            endcase
        end
        n_rd += int'(cam_read === 1'b1);
        n_wr += int'(cam_write === 1'b1);
        n_sr += int'(cam_search === 1'b1);
        if (int'(cam_read === 1'b1) + int'(cam_write === 1'b1) + int'(cam_search === 1'b1) > 1)
            multi_err++;
        if (rst) begin
            if (rsp_valid && rsp_ready)
                got_q.push_back({rsp_op, rsp_hit, rsp_index, rsp_data});
            if (p_hold && (rsp_valid !== 1'b1 || {rsp_op, rsp_hit, rsp_index, rsp_data} !== p_val))
                hold_err++;
            p_hold = rsp_valid && !rsp_ready;
            p_val = {rsp_op, rsp_hit, rsp_index, rsp_data};
        end else
            p_hold = 1'b0;
    end

    task automatic send(input logic [1:0] op, input logic [4:0] idx, input logic [31:0] d);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_index = idx;
        cmd_data = d;
        while (!cmd_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        n_cmp++;
        if (!cmd_ready) begin
            n_fail++;
            $display("FAIL send_timeout: cmd_ready=%b required 1", cmd_ready);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        rsp_ready = 1'b1;
        while (got_q.size() < exp_q.size() && n < 600) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cmd_valid = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({cmd_ready, cam_read, cam_write, cam_search, rsp_valid} !== 5'b0) begin
                n_fail++;
                $display("FAIL reset_hold: ready,rd,wr,sr,rsp_valid=%b required 00000",
                         {cmd_ready, cam_read, cam_write, cam_search, rsp_valid});
            end
        end
        rst = 1'b1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: cmd_ready=%b required 1", cmd_ready);
        end
        repeat (6) @(posedge clk);
        #1;
        n_cmp++;
        if (n_rd + n_wr + n_sr != 0 || rsp_valid !== 1'b0 || {rsp_op, rsp_hit, rsp_index, rsp_data} !== 40'd0) begin
            n_fail++;
            $display("FAIL reset_empty: strobes=%0d rsp_valid=%b rsp=%h required 0 0 0",
                     n_rd + n_wr + n_sr, rsp_valid, {rsp_op, rsp_hit, rsp_index, rsp_data});
        end
    endtask

    task automatic test_write_read();
        int n;
        rsp_ready = 1'b1;
        send(2'd1, 5'd7, 32'hDEADBEEF);
        repeat (6) @(posedge clk);
        #1;
        send(2'd0, 5'd7, 32'h0);
        n = 1;
        while (!rsp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        n_cmp++;
        if (n != 4) begin
            n_fail++;
            $display("FAIL read_latency: cycles=%0d required 4", n);
        end
        drain();
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL wr_rd_count: responses=%0d required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL wr_rd_rsp[%0d]: got %h required %h", i, i < got_q.size() ? got_q[i] : 40'hx, exp_q[i]);
            end
        end
        n_cmp++;
        if (n_wr != 1 || n_rd != 1) begin
            n_fail++;
            $display("FAIL wr_rd_strobes: writes=%0d reads=%0d required 1 1", n_wr, n_rd);
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_search();
        send(2'd2, 5'd0, 32'hDEADBEEF);
        send(2'd2, 5'd0, 32'h12345678);
        drain();
        n_cmp++;
        if (got_q.size() != 2 || exp_q.size() != 2) begin
            n_fail++;
            $display("FAIL search_count: responses=%0d model=%0d required 2", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL search_rsp[%0d]: got %h required %h", i, i < got_q.size() ? got_q[i] : 40'hx, exp_q[i]);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_fill();
        int n, acc;
        acc = 0;
        rsp_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cmd_valid = 1'b1;
            cmd_op = 2'd0;
            cmd_index = 5'(k + 3);
            cmd_data = '0;
            n = 0;
            while (!cmd_ready && n < 12) begin
                @(posedge clk); #1;
                n++;
            end
            if (!cmd_ready)
                break;
            @(posedge clk); #1;
            acc++;
        end
        n_cmp++;
        if (acc != DEPTH + 1 || cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_accept: accepted=%0d cmd_ready=%b required %0d 0", acc, cmd_ready, DEPTH + 1);
        end
        n_cmp++;
        if (rsp_valid !== 1'b1 || {rsp_op, rsp_hit, rsp_index, rsp_data} !== exp_q[0] || hold_err != 0) begin
            n_fail++;
            $display("FAIL fill_frozen: rsp_valid=%b rsp=%h hold_err=%0d required 1 %h 0",
                     rsp_valid, {rsp_op, rsp_hit, rsp_index, rsp_data}, hold_err, exp_q[0]);
        end
        cmd_valid = 1'b0;
        drain();
        n_cmp++;
        if (got_q.size() != DEPTH + 1) begin
            n_fail++;
            $display("FAIL fill_count: responses=%0d required %0d", got_q.size(), DEPTH + 1);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL fill_rsp[%0d]: got %h required %h", i, i < got_q.size() ? got_q[i] : 40'hx, exp_q[i]);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_reset_wait();
        int n, rd0, seen;
        rsp_ready = 1'b1;
        send(2'd0, 5'd7, 32'h0);
        n = 0;
        while (cam_read !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            n_cmp++;
            if (rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_wait_rsp: rsp_valid=%b required 0", rsp_valid);
            end
        end
        rst = 1'b1;
        exp_q.delete();
        got_q.delete();
        rd0 = n_rd + n_wr + n_sr;
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            seen += int'(rsp_valid === 1'b1);
        end
        n_cmp++;
        if (seen != 0 || n_rd + n_wr + n_sr != rd0 || got_q.size() != 0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_wait_discard: rsp_cycles=%0d new_strobes=%0d responses=%0d ready=%b required 0 0 0 1",
                     seen, n_rd + n_wr + n_sr - rd0, got_q.size(), cmd_ready);
        end
        send(2'd0, 5'd7, 32'h0);
        drain();
        n_cmp++;
        if (got_q.size() != 1 || exp_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            n_fail++;
            $display("FAIL reset_wait_after: responses=%0d first=%h required 1 %h",
                     got_q.size(), got_q.size() > 0 ? got_q[0] : 40'hx, exp_q.size() > 0 ? exp_q[0] : 40'hx);
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_write_ack();
        send(2'd1, 5'd3, 32'hA5);
        drain();
`ifdef CAM_CMD_QUEUE_WR_ACK_EN
        n_cmp++;
        if (got_q.size() != 1 || got_q[0] !== {2'd1, 1'b1, 5'd3, 32'hA5}) begin
            n_fail++;
            $display("FAIL write_ack: responses=%0d first=%h required 1 %h",
                     got_q.size(), got_q.size() > 0 ? got_q[0] : 40'hx, {2'd1, 1'b1, 5'd3, 32'hA5});
        end
`else
        n_cmp++;
        if (got_q.size() != 0) begin
            n_fail++;
            $display("FAIL write_no_ack: responses=%0d required 0", got_q.size());
        end
`endif
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_back_to_back();
        logic done;
        logic [31:0] d;
        done = 1'b0;
        fork
            begin
                for (int k = 0; k < 60; k++) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                    case ($urandom_range(0, 3))
                        0: d = 32'hA5;
                        1: d = 32'hDEADBEEF;
                        2: d = 32'h1;
                        default: d = 32'h2;
                    endcase
                    send(2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), d);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    rsp_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        drain();
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rand_count: responses=%0d required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rand_rsp[%0d]: got %h required %h", i, i < got_q.size() ? got_q[i] : 40'hx, exp_q[i]);
            end
        end
        n_cmp++;
        if (n_rd != e_rd || n_wr != e_wr || n_sr != e_sr) begin
            n_fail++;
            $display("FAIL rand_strobes: rd/wr/sr=%0d/%0d/%0d required %0d/%0d/%0d", n_rd, n_wr, n_sr, e_rd, e_wr, e_sr);
        end
        n_cmp++;
        if (multi_err != 0 || hold_err != 0) begin
            n_fail++;
            $display("FAIL rand_protocol: multi_strobe=%0d hold_violations=%0d required 0 0", multi_err, hold_err);
        end
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time=%0t required finish before 2000000", $time);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_read();
        test_search();
        test_fill();
        test_reset_wait();
        test_write_ack();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
